// File: rtl/rom_prefetch.sv
`default_nettype none
// rom_prefetch: prefetches 32-bit ROM words into a small FIFO and serves PI-bus halfwords.
// Optional: define ROM_BYTESWAP_EN to swap bytes within each halfword before storage (.v64 images).
module rom_prefetch #(
    parameter int ADDR_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_valid_i,
    input  logic [31:0]       addr_i,
    input  logic              rd_pulse_i,
    output logic [15:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_underrun_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i,
    output logic              busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t              state_q;
    logic                burst_q;
    logic [ADDR_W-1:0]   next_addr_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;

    logic [31:0]         fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                half_sel_q, half_sel_d;
    logic [15:0]         rd_data_q;
    logic                rd_valid_q;
    logic                rd_underrun_q;

    logic                push, pop, rd_ok, underrun_d;
    logic [31:0]         push_data, head_d;
    logic [ADDR_W-1:0]   new_addr;
    logic                unused_addr_bits;

    assign new_addr         = addr_i[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[0]};

`ifdef ROM_BYTESWAP_EN
    assign push_data = {mem_data_i[23:16], mem_data_i[31:24], mem_data_i[7:0], mem_data_i[15:8]};
`else
    assign push_data = mem_data_i;
`endif

    // A new address phase overrides both the read strobe and any data landing this cycle.
    assign push       = (state_q == FETCH) && mem_ack_i && !addr_valid_i;
    assign rd_ok      = rd_pulse_i && !addr_valid_i && (count_q != '0);
    assign underrun_d = rd_pulse_i && !addr_valid_i && (count_q == '0);
    assign pop        = rd_ok && half_sel_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        half_sel_d = rd_ok ? ~half_sel_q : half_sel_q;
        if (addr_valid_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            half_sel_d = addr_i[1];
        end
        // When the FIFO drains to nothing this cycle, the only candidate head is the incoming word.
        if (count_q == (PTR_W+1)'(pop)) begin
            head_d = push_data;
        end else begin
            head_d = fifo_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            half_sel_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_underrun_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            half_sel_q    <= half_sel_d;
            rd_data_q     <= half_sel_d ? head_d[15:0] : head_d[31:16];
            rd_valid_q    <= (count_d != '0);
            rd_underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_q     <= 1'b0;
            next_addr_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            if (addr_valid_i) begin
                burst_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (addr_valid_i) begin
                        next_addr_q <= new_addr;
                        mem_addr_q  <= new_addr;
                        mem_req_q   <= 1'b1;
                        state_q     <= FETCH;
                    end else if (burst_q && (count_d < C_FULL)) begin
                        mem_addr_q  <= next_addr_q;
                        mem_req_q   <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack_i) begin
                        mem_req_q   <= 1'b0;
                        state_q     <= IDLE;
                        next_addr_q <= addr_valid_i ? new_addr : next_addr_q + 1'b1;
                    end else if (addr_valid_i) begin
                        next_addr_q <= new_addr;
                        state_q     <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (addr_valid_i) begin
                        next_addr_q <= new_addr;
                    end
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_underrun_o = rd_underrun_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign busy_o        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_prefetch.sv
`default_nettype none
// tb_rom_prefetch: directed stimulus with a queue-based reference model checked every cycle.
module tb_rom_prefetch;

    localparam int ADDR_W = 24;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              addr_valid_i = 1'b0;
    logic [31:0]       addr_i = '0;
    logic              rd_pulse_i = 1'b0;
    logic [15:0]       rd_data_o;
    logic              rd_valid_o;
    logic              rd_underrun_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i = 1'b0;
    logic [31:0]       mem_data_i = '0;
    logic              busy_o;

    always #5 clk = ~clk;

    rom_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_valid_i(addr_valid_i), .addr_i(addr_i), .rd_pulse_i(rd_pulse_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_underrun_o(rd_underrun_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .busy_o(busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 0;
    int lat_cnt = 0;
    int und_seen = 0;
    logic [ADDR_W-1:0] req_log [$];

    // Reference model: the FIFO is a plain queue of stored words.
    logic [31:0]       mq [$];
    logic              m_half = 1'b0;
    logic              m_burst = 1'b0;
    logic              m_req = 1'b0;
    logic              m_stale = 1'b0;
    logic              m_und = 1'b0;
    logic [ADDR_W-1:0] m_next = '0;
    logic [ADDR_W-1:0] m_req_addr = '0;

    logic [15:0] t1_exp [4] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};

    function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
        case (a)
            24'h000000: rom = 32'h11223344;
            24'h000001: rom = 32'h55667788;
            24'h000002: rom = 32'h22114433;
            24'h006D08: rom = 32'hAABBCCDD;
            default:    rom = {a[15:0] ^ 16'hF00F, a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] swap(input logic [31:0] w);
`ifdef ROM_BYTESWAP_EN
        swap = {w[23:16], w[31:24], w[7:0], w[15:8]};
`else
        swap = w;
`endif
    endfunction

    // Halfword as it appears on the bus given the raw image halfword.
    function automatic logic [15:0] hw(input logic [15:0] h);
`ifdef ROM_BYTESWAP_EN
        hw = {h[7:0], h[15:8]};
`else
        hw = h;
`endif
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check();
        cmp("rd_valid", 32'(rd_valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0)
            cmp("rd_data", 32'(rd_data_o), 32'(m_half ? mq[0][15:0] : mq[0][31:16]));
        cmp("rd_underrun", 32'(rd_underrun_o), 32'(m_und));
        cmp("mem_req", 32'(mem_req_o), 32'(m_req));
        cmp("busy", 32'(busy_o), 32'(m_req));
        if (m_req)
            cmp("mem_addr", 32'(mem_addr_o), 32'(m_req_addr));
        if (rd_underrun_o) und_seen++;
    endtask

    task automatic model_update(input logic av, input logic [31:0] a, input logic rp, input logic ack);
        logic        req_was;
        int          old;
        logic [31:0] dummy;
        req_was = m_req;
        old     = mq.size();
        m_und   = 1'b0;
        if (av) begin
            mq.delete();
            m_half  = a[1];
            m_burst = 1'b1;
            m_next  = a[ADDR_W+1:2];
        end else begin
            if (rp) begin
                if (old == 0) m_und = 1'b1;
                else if (m_half) begin
                    dummy  = mq.pop_front();
                    m_half = 1'b0;
                end else m_half = 1'b1;
            end
            if (req_was && ack && !m_stale) begin
                mq.push_back(swap(rom(m_req_addr)));
                m_next = m_next + 1'b1;
            end
        end
        if (req_was && ack) begin
            m_req   = 1'b0;
            m_stale = 1'b0;
        end else if (av && req_was) begin
            m_stale = 1'b1;
        end
        if (!req_was && m_burst && mq.size() < DEPTH) begin
            m_req      = 1'b1;
            m_req_addr = m_next;
        end
    endtask

    // One bus cycle: check outputs, act as the memory, drive inputs, advance the model.
    task automatic step(input logic av, input logic [31:0] a, input logic rp);
        logic        ack;
        logic [31:0] d;
        ack = 1'b0;
        d   = '0;
        @(negedge clk);
        check();
        if (mem_req_o) begin
            if (lat_cnt == 0) req_log.push_back(mem_addr_o);
            if (lat_cnt >= lat) begin
                ack     = 1'b1;
                d       = rom(mem_addr_o);
                lat_cnt = 0;
            end else lat_cnt++;
        end
        addr_valid_i = av;
        addr_i       = a;
        rd_pulse_i   = rp;
        mem_ack_i    = ack;
        mem_data_i   = d;
        model_update(av, a, rp, ack);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic start(input logic [31:0] a);
        step(1'b1, a, 1'b0);
        step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic pulse();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!rd_valid_o && n < 60) begin
            step(1'b0, 32'h0, 1'b0);
            n++;
        end
        cmp(nm, 32'(rd_valid_o), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        cmp("rst_rd_data", 32'(rd_data_o), 32'h0);
        cmp("rst_rd_valid", 32'(rd_valid_o), 32'h0);
        cmp("rst_underrun", 32'(rd_underrun_o), 32'h0);
        cmp("rst_mem_req", 32'(mem_req_o), 32'h0);
        cmp("rst_mem_addr", 32'(mem_addr_o), 32'h0);
        cmp("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;
        idle(5);
        cmp("pre_burst_no_req", 32'(req_log.size()), 32'd0);

        // Sequential burst from address 0 with latency 3.
        lat = 3; req_log.delete(); und_seen = 0;
        start(32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            wait_valid("t1_valid");
            cmp("t1_halfword", 32'(rd_data_o), 32'(hw(t1_exp[i])));
            pulse();
        end
        cmp("t1_nreq", 32'(req_log.size() >= 2), 32'd1);
        cmp("t1_addr0", 32'(req_log[0]), 32'h0);
        cmp("t1_addr1", 32'(req_log[1]), 32'h1);
        cmp("t1_no_underrun", 32'(und_seen), 32'd0);
        idle(30);

        // Odd halfword start address.
        req_log.delete();
        start(32'h0001_B422);
        wait_valid("t2_valid");
        cmp("t2_addr", 32'(req_log[0]), 32'h6D08);
        cmp("t2_first", 32'(rd_data_o), 32'(hw(16'hCCDD)));
        pulse();
        wait_valid("t2_valid2");
        cmp("t2_second", 32'(rd_data_o), 32'(hw(16'h9D06)));
        idle(30);

        // Zero-wait memory fills the FIFO, then one consumed word allows one more request.
        lat = 0; req_log.delete();
        start(32'h0000_0200);
        idle(20);
        cmp("t3_fill_nreq", 32'(req_log.size()), 32'(DEPTH));
        cmp("t3_full_noreq", 32'(mem_req_o), 32'd0);
        pulse();
        pulse();
        idle(10);
        cmp("t3_refill_nreq", 32'(req_log.size()), 32'(DEPTH + 1));
        idle(10);

        // New address while the request for word 5 is pending.
        lat = 4; req_log.delete();
        step(1'b1, 32'h0000_0014, 1'b0);
        idle(2);
        step(1'b1, 32'h0000_0100, 1'b0);
        idle(2);
        wait_valid("t4_valid");
        cmp("t4_nreq", 32'(req_log.size() >= 2), 32'd1);
        cmp("t4_addr0", 32'(req_log[0]), 32'h5);
        cmp("t4_addr1", 32'(req_log[1]), 32'h40);
        cmp("t4_first", 32'(rd_data_o), 32'(hw(16'hF04F)));
        idle(40);

        // Read strobe before any data has arrived.
        lat = 3; und_seen = 0;
        step(1'b1, 32'h0000_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        cmp("t5_underrun", 32'(rd_underrun_o), 32'd1);
        cmp("t5_not_valid", 32'(rd_valid_o), 32'd0);
        step(1'b0, 32'h0, 1'b0);
        cmp("t5_underrun_pulse", 32'(rd_underrun_o), 32'd0);
        wait_valid("t5_valid");
        cmp("t5_first", 32'(rd_data_o), 32'(hw(16'h1122)));
        idle(30);

        // Address phase and read strobe together; word 2 exercises byte order.
        und_seen = 0;
        step(1'b1, 32'h0000_0008, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        wait_valid("t6_valid");
        cmp("t6_no_underrun", 32'(und_seen), 32'd0);
        cmp("t6_hw0", 32'(rd_data_o), 32'(hw(16'h2211)));
        pulse();
        cmp("t6_hw1", 32'(rd_data_o), 32'(hw(16'h4433)));
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_prefetch.md
# rom_prefetch

Read-prefetch stage between the N64 PI bus front end and the cartridge ROM memory port. The front end latches the 32-bit byte address from the ALE_H/ALE_L phases and reports each completed READ_N strobe; this block fetches 32-bit ROM words ahead of the bus into a small FIFO. It presents the next 16-bit halfword so the front end can drive N64_AD without waiting on memory latency. Every new address phase restarts the burst and flushes stale data.

## Interface
- ADDR_W, 24: memory word-address width (ROM size = 4·2^ADDR_W bytes).
- DEPTH, 4: FIFO depth in 32-bit words; power of two, ≥2.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- addr_valid  in  1  one-cycle pulse: new burst address on addr.
- addr  in  32  PI byte address; bit 0 ignored.
- rd_pulse  in  1  one-cycle pulse: the bus consumed the current halfword (READ_N rising, already synchronised).
- rd_data  out  16  halfword for the next bus read.
- rd_valid  out  1  rd_data is valid.
- rd_underrun  out  1  one-cycle pulse: rd_pulse arrived while rd_valid=0.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  word address of the request.
- mem_ack  in  1  one-cycle pulse: mem_data valid; completes the request.
- mem_data  in  32  ROM word; bits[31:16] = byte offset 0.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, FETCH, DISCARD.
- addr_valid latches the following:
  - next_addr = addr[ADDR_W+1:2]
  - half_sel = addr[1]
  - FIFO emptied; rd_valid=0
- IDLE → FETCH when a burst is active and the FIFO has a free slot (count + outstanding < DEPTH). mem_req=1, mem_addr=next_addr.
- FETCH: hold mem_req and mem_addr until mem_ack. On ack:
  - push mem_data;
  - next_addr += 1, wrapping modulo 2^ADDR_W;
  - go to IDLE.
- addr_valid while in FETCH without ack → DISCARD. Keep mem_req and mem_addr unchanged until mem_ack, drop that data, then IDLE, which issues the new address.
- addr_valid in the same cycle as mem_ack: the acked data is dropped and the new burst starts; no DISCARD.
- Halfword select:
  - rd_data = head[31:16] if half_sel=0, else head[15:0].
  - rd_pulse with rd_valid=1 toggles half_sel; on 1→0 the head word is popped.
- rd_pulse with rd_valid=0: rd_underrun=1, no pointer change, half_sel unchanged.
- addr_valid and rd_pulse in the same cycle: addr_valid wins; rd_pulse ignored, no underrun.
- Before the first addr_valid after reset, no requests are issued.

## Timing
- All outputs registered.
- Reset values: rd_data=0, rd_valid=0, rd_underrun=0, mem_req=0, mem_addr=0, busy=0. FIFO empty, half_sel=0, state IDLE, burst inactive.
- addr_valid at cycle 0 → mem_req=1 at cycle 1.
- mem_ack at cycle k → rd_valid=1 and rd_data updated at k+1 (when FIFO previously empty).
- mem_req drops for exactly one cycle after each ack; peak rate is one word per 2 cycles with zero-wait memory.
- rd_pulse at cycle n → rd_data shows the next halfword at n+1. rd_valid falls at n+1 if the FIFO is then empty.
- FIFO full (count=DEPTH): mem_req stays 0 until a pop.
- Reset mid-request abandons the request; the memory side must tolerate an unanswered mem_req.

## Configuration
- ROM_BYTESWAP_EN defined: mem_data bytes are swapped within each halfword before the push ({[23:16],[31:24],[7:0],[15:8]}), for byte-swapped (.v64) ROM images.
- Undefined: mem_data is stored unchanged (.z64 order).

## Test plan
- addr=0x0000_0000, word 0 = 0x11223344, word 1 = 0x55667788, ack latency 3 → mem_addr 0 then 1; four rd_pulses yield 0x1122, 0x3344, 0x5566, 0x7788; no underrun.
- addr=0x0001_B422, word 0x6D08 = 0xAABBCCDD → mem_addr=0x6D08; first rd_data=0xCCDD; next read comes from word 0x6D09.
- Zero-wait memory, no rd_pulse → exactly DEPTH requests, then mem_req stays 0. One word (two pulses) consumed → exactly one more request.
- addr_valid to 0x100 while the request for word 5 is pending, ack after 4 cycles → mem_addr stays 5 until ack, data dropped, next mem_addr=0x40; first rd_data comes from word 0x40.
- rd_pulse before the first ack → rd_underrun one-cycle pulse, rd_valid=0; the following data is still delivered from halfword 0.
- ROM_BYTESWAP_EN build, word 0x22114433 → rd_data 0x1122, then 0x3344.
